// File: rtl/rd_ptr_empty_lvl.sv
// rtl/rd_ptr_empty_lvl.sv - async FIFO read-side pointer, empty/level/almost-empty and error status
module rd_ptr_empty_lvl #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  rd_clk_i,
    input  logic                  rd_rstn_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH:0]   rq2_wptr_i,
    input  logic [ADDR_WIDTH:0]   ae_thresh_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [ADDR_WIDTH:0]   rd_ptr_o,
    output logic [ADDR_WIDTH:0]   rd_count_o,
    output logic                  empty_o,
    output logic                  a_empty_o,
    output logic                  rd_valid_o,
    output logic                  underflow_o,
    output logic                  ptr_err_o
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] wbin;
    logic [PW-1:0] lvl;
    logic          rd_acc;
    logic          lvl_over;

    // Accept depends only on registered empty, never on the incoming write pointer
    assign rd_acc    = rd_en_i & ~empty_o;
    assign rbinnext  = rbin + {{ADDR_WIDTH{1'b0}}, rd_acc};
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;
    assign rd_addr_o = rbin[ADDR_WIDTH-1:0];

    always_comb begin
        wbin = '0;
        wbin[PW-1] = rq2_wptr_i[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ rq2_wptr_i[i];
        end
    end

    // Read and write movement are folded into one difference, so the count change is net
    assign lvl      = wbin - rbinnext;
    assign lvl_over = (lvl > DEPTH_P);

    always_ff @(posedge rd_clk_i) begin
        if (!rd_rstn_i) begin
            rbin        <= '0;
            rd_ptr_o    <= '0;
            rd_count_o  <= '0;
            empty_o     <= 1'b1;
            a_empty_o   <= 1'b1;
            rd_valid_o  <= 1'b0;
            underflow_o <= 1'b0;
            ptr_err_o   <= 1'b0;
        end else begin
            rbin        <= rbinnext;
            rd_ptr_o    <= rgraynext;
            rd_count_o  <= lvl_over ? DEPTH_P : lvl;
            empty_o     <= (rgraynext == rq2_wptr_i);
            a_empty_o   <= (lvl <= ae_thresh_i);
            rd_valid_o  <= rd_acc;
            underflow_o <= rd_en_i & empty_o;
            ptr_err_o   <= ptr_err_o | lvl_over;
        end
    end

endmodule

// File: tb/tb_rd_ptr_empty_lvl.sv
// tb/tb_rd_ptr_empty_lvl.sv - vector table, corner sequences and random run against a reference model
module tb_rd_ptr_empty_lvl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int MOD   = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rd_en;
    logic [AW:0]   wptr;
    logic [AW:0]   thresh;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   rd_count;
    logic          empty, a_empty, rd_valid, underflow, ptr_err;

    always #5 clk = ~clk;

    rd_ptr_empty_lvl #(.ADDR_WIDTH(AW)) dut (
        .rd_clk_i    (clk),
        .rd_rstn_i   (rstn),
        .rd_en_i     (rd_en),
        .rq2_wptr_i  (wptr),
        .ae_thresh_i (thresh),
        .rd_addr_o   (rd_addr),
        .rd_ptr_o    (rd_ptr),
        .rd_count_o  (rd_count),
        .empty_o     (empty),
        .a_empty_o   (a_empty),
        .rd_valid_o  (rd_valid),
        .underflow_o (underflow),
        .ptr_err_o   (ptr_err)
    );

    typedef struct {
        bit   rstn;
        bit   en;
        int   wg;
        int   cnt;
        bit   emp;
        bit   ae;
        bit   vld;
        bit   unf;
        bit   err;
        int   addr;
    } vec_t;

    vec_t tv[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference state: read position as a plain count, status as the last registered values
    int m_rb, m_cnt;
    bit m_emp, m_ae, m_vld, m_unf, m_err;
    int mw;

    function automatic int bin2gray(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    function automatic int gray2bin(input int g);
        int b = 0;
        for (int i = AW; i >= 0; i--) begin
            int acc = 0;
            for (int j = AW; j >= i; j--) acc ^= (g >> j) & 1;
            b |= acc << i;
        end
        return b;
    endfunction

    function automatic void add(input bit r, input bit e, input int wg, input int cnt, input bit emp,
                                input bit ae, input bit vld, input bit unf, input bit err, input int addr);
        vec_t v;
        v.rstn = r; v.en = e; v.wg = wg; v.cnt = cnt; v.emp = emp;
        v.ae = ae; v.vld = vld; v.unf = unf; v.err = err; v.addr = addr;
        tv.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input int wg, input int th);
        int acc, lvl;
        if (!r) begin
            m_rb = 0; m_cnt = 0; m_emp = 1; m_ae = 1;
            m_vld = 0; m_unf = 0; m_err = 0;
        end else begin
            acc   = (e && !m_emp) ? 1 : 0;
            m_unf = e && m_emp;
            m_rb  = (m_rb + acc) % MOD;
            lvl   = (gray2bin(wg) - m_rb + MOD) % MOD;
            m_emp = (lvl == 0);
            m_cnt = (lvl > DEPTH) ? DEPTH : lvl;
            m_ae  = (lvl <= th);
            m_vld = (acc == 1);
            m_err = m_err || (lvl > DEPTH);
        end
    endtask

    task automatic drive(input bit r, input bit e, input int wg, input int th);
        @(negedge clk);
        rstn   = r;
        rd_en  = e;
        wptr   = (AW+1)'(wg);
        thresh = (AW+1)'(th);
        model_step(r, e, wg, th);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        check("count",     int'(rd_count),  m_cnt);
        check("empty",     int'(empty),     int'(m_emp));
        check("a_empty",   int'(a_empty),   int'(m_ae));
        check("rd_valid",  int'(rd_valid),  int'(m_vld));
        check("underflow", int'(underflow), int'(m_unf));
        check("ptr_err",   int'(ptr_err),   int'(m_err));
        check("rd_ptr",    int'(rd_ptr),    bin2gray(m_rb));
        check("rd_addr",   int'(rd_addr),   m_rb % DEPTH);
    endtask

    initial begin
        int th;
        int prev_ptr;
        rstn = 0; rd_en = 0; wptr = '0; thresh = 5'd2;
        m_rb = 0; m_cnt = 0; m_emp = 1; m_ae = 1; m_vld = 0; m_unf = 0; m_err = 0;

        //   rstn en  wg  cnt emp ae vld unf err addr
        add(0, 0, 3,  0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 3,  0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 3,  0, 1, 1, 0, 0, 0, 0);
        add(1, 0, 0,  0, 1, 1, 0, 0, 0, 0);
        add(1, 0, 1,  1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 3,  2, 0, 1, 0, 0, 0, 0);
        add(1, 0, 2,  3, 0, 0, 0, 0, 0, 0);
        add(1, 0, 6,  4, 0, 0, 0, 0, 0, 0);
        add(1, 0, 7,  5, 0, 0, 0, 0, 0, 0);
        add(1, 1, 7,  4, 0, 0, 1, 0, 0, 1);
        add(1, 1, 7,  3, 0, 0, 1, 0, 0, 2);
        add(1, 1, 7,  2, 0, 1, 1, 0, 0, 3);
        add(1, 1, 7,  1, 0, 1, 1, 0, 0, 4);
        add(1, 1, 7,  0, 1, 1, 1, 0, 0, 5);
        add(1, 1, 7,  0, 1, 1, 0, 1, 0, 5);
        add(1, 0, 7,  0, 1, 1, 0, 0, 0, 5);
        add(1, 0, 13, 4, 0, 0, 0, 0, 0, 5);
        add(1, 1, 15, 4, 0, 0, 1, 0, 0, 6);
        add(1, 0, 23, 16, 0, 0, 0, 0, 1, 6);
        add(1, 0, 15, 4, 0, 0, 0, 0, 1, 6);
        add(0, 0, 15, 0, 1, 1, 0, 0, 0, 0);
        add(1, 0, 0,  0, 1, 1, 0, 0, 0, 0);

        foreach (tv[i]) begin
            drive(tv[i].rstn, tv[i].en, tv[i].wg, 2);
            check($sformatf("vec%0d.count", i),     int'(rd_count),  tv[i].cnt);
            check($sformatf("vec%0d.empty", i),     int'(empty),     int'(tv[i].emp));
            check($sformatf("vec%0d.a_empty", i),   int'(a_empty),   int'(tv[i].ae));
            check($sformatf("vec%0d.rd_valid", i),  int'(rd_valid),  int'(tv[i].vld));
            check($sformatf("vec%0d.underflow", i), int'(underflow), int'(tv[i].unf));
            check($sformatf("vec%0d.ptr_err", i),   int'(ptr_err),   int'(tv[i].err));
            check($sformatf("vec%0d.rd_addr", i),   int'(rd_addr),   tv[i].addr);
        end

        // Fill to full then drain, three rounds so the binary pointer wraps past 31
        mw = 0;
        for (int round = 0; round < 3; round++) begin
            mw = (m_rb + DEPTH) % MOD;
            drive(1, 0, bin2gray(mw), 2);
            check("full.count", int'(rd_count), DEPTH);
            check("full.ptr_err", int'(ptr_err), 0);
            check_model();
            for (int k = 0; k < DEPTH; k++) begin
                prev_ptr = int'(rd_ptr);
                drive(1, 1, bin2gray(mw), 2);
                check("drain.gray_step", $countones(prev_ptr ^ int'(rd_ptr)), 1);
                check_model();
            end
            check("drain.empty", int'(empty), 1);
        end

        // Random reads and bursty write-pointer jumps that never overfill
        th = 3;
        for (int it = 0; it < 600; it++) begin
            int adv, cur;
            bit en, r;
            if ($urandom_range(0, 49) == 0) th = $urandom_range(0, DEPTH);
            r   = ($urandom_range(0, 149) != 0);
            en  = $urandom_range(0, 1) == 1;
            adv = $urandom_range(0, 3);
            cur = (mw - m_rb + MOD) % MOD;
            if (cur + adv <= DEPTH) mw = (mw + adv) % MOD;
            if (!r) mw = 0;
            drive(r, en, bin2gray(mw), th);
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
